// File: rtl/downcounter_pkg.sv
// Shared types and constants for the even down-counter datapath.
// Imported by the counter core and its controller.
package downcounter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } ctrl_state_t;

    localparam int STEP          = 2;
    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/even_down_core.sv
// Even down-counter register: loads an even value, steps down by STEP.
// The controller guarantees dec is never asserted at zero.
module even_down_core
    import downcounter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            // LSB is forced low so the value stays even.
            count_d = {load_val[WIDTH-1:1], 1'b0};
        end else if (dec) begin
            count_d = count_q - WIDTH'(STEP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/even_down_count_ctrl.sv
// Two-requester round-robin controller for the even down-counter core.
// Grants in IDLE, counts to zero, then pulses done to the job's owner.
module even_down_count_ctrl
    import downcounter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [1:0][WIDTH-1:0] req_start,
    output logic [1:0]            req_ready,
    input  logic                  hold,
    input  logic                  abort,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  owner,
    output logic [1:0]            done
);

    ctrl_state_t      state_d;
    ctrl_state_t      state_q;
    logic             ptr_d;
    logic             ptr_q;
    logic             owner_d;
    logic             owner_q;
    logic             busy_d;
    logic             busy_q;
    logic [1:0]       done_d;
    logic [1:0]       done_q;

    logic             gnt_vld;
    logic             gnt;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dec;
    logic [WIDTH-1:0] cnt;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);

    // Round-robin grant, only offered while idle.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = ptr_q;
        if (state_q == IDLE) begin
            if (req_valid[ptr_q]) begin
                gnt_vld = 1'b1;
                gnt     = ptr_q;
            end else if (req_valid[~ptr_q]) begin
                gnt_vld = 1'b1;
                gnt     = ~ptr_q;
            end
        end
    end

    assign req_ready = gnt_vld ? (2'b01 << gnt) : 2'b00;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        load     = 1'b0;
        load_val = '0;
        dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    load     = 1'b1;
                    load_val = req_start[gnt];
                    owner_d  = gnt;
                    state_d  = COUNT;
                end
            end
            COUNT: begin
                if (abort) begin
                    load     = 1'b1;
                    load_val = '0;
                    ptr_d    = ~owner_q;
                    state_d  = IDLE;
                end else if (cnt_zero) begin
                    state_d = DONE;
                end else if (!hold) begin
                    dec = 1'b1;
                end
            end
            DONE: begin
                ptr_d   = ~owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next-state decode.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = 2'b00;
        if (state_d == DONE) begin
            done_d[owner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    even_down_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .load_val(load_val),
        .dec     (dec),
        .count   (cnt)
    );

    assign count = cnt;
    assign busy  = busy_q;
    assign owner = owner_q;
    assign done  = done_q;

endmodule

// File: tb/tb_even_down_count_ctrl.sv
// Directed bench for even_down_count_ctrl: single jobs, arbitration,
// hold, abort and asynchronous reset.
module tb_even_down_count_ctrl;

    logic            clk;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0][7:0] req_start;
    logic [1:0]      req_ready;
    logic            hold;
    logic            abort;
    logic [7:0]      count;
    logic            busy;
    logic            owner;
    logic [1:0]      done;

    int n_cmp;
    int n_bad;

    even_down_count_ctrl #(
        .WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_start(req_start),
        .req_ready(req_ready),
        .hold     (hold),
        .abort    (abort),
        .count    (count),
        .busy     (busy),
        .owner    (owner),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int idx, input logic [7:0] s);
        logic [7:0] c;
        logic [1:0] bit_i;
        c     = s & 8'hFE;
        bit_i = 2'b01 << idx;
        req_start[idx] = s;
        req_valid[idx] = 1'b1;
        #1;
        chk("job_ready", req_ready, bit_i);
        tick();
        req_valid[idx] = 1'b0;
        chk("job_load", count, c);
        chk("job_owner", owner, idx);
        chk("job_busy", busy, 1);
        for (int k = 1; k <= c / 2; k++) begin
            tick();
            chk("job_cnt", count, c - 8'(2 * k));
            chk("job_nodone", done, 0);
        end
        tick();
        chk("job_done", done, bit_i);
        tick();
        chk("job_done_off", done, 0);
        chk("job_idle", busy, 0);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b0;
        req_valid = 2'b00;
        req_start = '0;
        hold      = 1'b0;
        abort     = 1'b0;
        #8 rst = 1'b1;

        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_owner", owner, 0);
        chk("rst_ready", req_ready, 0);

        // Start 8: 8,6,4,2,0 then done
        run_job(0, 8'd8);
        // Odd start loads 6; start 1 loads 0
        run_job(0, 8'd7);
        run_job(0, 8'd1);

        // Contention from reset
        rst = 1'b0;
        #2 rst = 1'b1;
        req_start[0] = 8'd4;
        req_start[1] = 8'd2;
        req_valid    = 2'b11;
        #1;
        chk("arb_first", req_ready, 2'b01);
        tick();
        req_valid = 2'b10;
        chk("arb_own0", owner, 0);
        chk("arb_cnt4", count, 4);
        chk("arb_busy_rdy", req_ready, 0);
        tick();
        chk("arb_cnt2", count, 2);
        tick();
        chk("arb_cnt0", count, 0);
        tick();
        chk("arb_done0", done, 2'b01);
        tick();
        req_valid = 2'b11;
        #1;
        chk("arb_second", req_ready, 2'b10);
        tick();
        req_valid = 2'b01;
        chk("arb_own1", owner, 1);
        chk("arb_cnt2b", count, 2);
        tick();
        chk("arb_cnt0b", count, 0);
        tick();
        chk("arb_done1", done, 2'b10);
        tick();
        #1;
        chk("arb_third", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        chk("arb_own0b", owner, 0);
        tick();
        tick();
        tick();
        chk("arb_done0b", done, 2'b01);
        tick();

        // Hold stretches count=4 by 3 cycles; hold at 0 ignored
        req_start[0] = 8'd6;
        req_valid    = 2'b01;
        tick();
        req_valid = 2'b00;
        chk("hold_cnt6", count, 6);
        tick();
        chk("hold_cnt4", count, 4);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_frozen", count, 4);
        end
        hold = 1'b0;
        tick();
        chk("hold_cnt2", count, 2);
        tick();
        chk("hold_cnt0", count, 0);
        hold = 1'b1;
        tick();
        chk("hold_done", done, 2'b01);
        hold = 1'b0;
        tick();
        chk("hold_idle", busy, 0);

        // Abort at count 6
        req_start[0] = 8'd10;
        req_valid    = 2'b01;
        tick();
        req_valid = 2'b00;
        chk("abt_cnt10", count, 10);
        tick();
        tick();
        chk("abt_cnt6", count, 6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt_cnt0", count, 0);
        chk("abt_busy", busy, 0);
        chk("abt_done", done, 0);
        tick();
        chk("abt_nodone", done, 0);
        req_start[1] = 8'd8;
        req_valid    = 2'b11;
        #1;
        chk("abt_ptr", req_ready, 2'b10);

        // Async reset mid-job with owner 1
        tick();
        req_valid = 2'b00;
        chk("ar_own1", owner, 1);
        chk("ar_cnt8", count, 8);
        tick();
        tick();
        chk("ar_cnt4", count, 4);
        #2 rst = 1'b0;
        #1;
        chk("ar_count", count, 0);
        chk("ar_busy", busy, 0);
        chk("ar_owner", owner, 0);
        chk("ar_done", done, 0);
        rst       = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("ar_ptr", req_ready, 2'b01);
        req_valid = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/even_down_count_ctrl.md
# even_down_count_ctrl

Controller and two-requester arbiter for the 8-bit even down-counter datapath. It accepts count jobs (a start value) from two requesters over valid/ready, grants the shared counter round-robin, loads the start value forced even, steps it down by 2 to zero, and returns a one-cycle done pulse to the job's owner. It sits between the requesting logic and the counter core, which it instantiates.

## Interface
Parameters:
- WIDTH, 8, counter and start-value width (must be ≥ 2).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-low.
- req_valid  input  2  per-requester job valid; once asserted, held until accepted.
- req_start  input  2×WIDTH  per-requester start value; stable while valid.
- req_ready  output  2  per-requester accept; a transfer occurs on an edge where valid[i] && ready[i].
- hold  input  1  freezes decrement while high.
- abort  input  1  cancels the running job.
- count  output  WIDTH  current counter value.
- busy  output  1  high in COUNT and DONE.
- owner  output  1  index of the requester that owns the current or most recent job.
- done  output  2  one-cycle completion pulse, one bit per requester.

## Operation
- Reset values:
  - state = IDLE, count = 0, busy = 0, done = 0, owner = 0.
  - Round-robin pointer ptr = 0.
  - req_ready = 0.
- Grant (combinational, IDLE only):
  - If req_valid[ptr], grant ptr; else if req_valid[~ptr], grant ~ptr; else no grant.
  - req_ready[g] = (state == IDLE) for the granted g only; at most one ready bit is high.
  - Ready may depend on valid; valid must not depend on ready.
- States:
  - IDLE: on accept, count <= start & ~1 (LSB cleared), owner <= g, go to COUNT.
  - COUNT:
    - If abort: go to IDLE, count <= 0, no done pulse, ptr <= ~owner.
    - Else if count == 0: go to DONE.
    - Else if hold: no change.
    - Else count <= count − 2.
  - DONE: done[owner] = 1 for exactly this cycle; next edge goes to IDLE and sets ptr <= ~owner. Abort in DONE is ignored.
- Arithmetic: count is always even and never wraps below 0. Start values 0 and 1 both load 0 and reach DONE one edge later.
- Asynchronous reset mid-job returns all state to reset values immediately, with no done pulse.

## Timing
- The accept edge (e0) loads count = S', where S' is the start value with its LSB cleared.
- With no hold: count = 0 after edge S'/2; the DONE state (done pulse high) begins after edge S'/2+1.
  - Example: S = 8 gives 8, 6, 4, 2, 0, then done during the cycle after the 5th edge.
- Each cycle hold is high in COUNT (with count ≠ 0) adds one cycle of latency.
- Hold is not sampled when count == 0; DONE is entered regardless.
- Abort is sampled on any COUNT edge and takes priority over hold and terminal count.
- Turnaround: DONE → IDLE takes 1 edge; the next accept occurs on the following edge at the earliest. Minimum spacing between accepts is S'/2+3 edges.
- busy rises the cycle after accept and falls the cycle after DONE.
- Outputs are registered except req_ready, which is combinational from state, ptr and req_valid.

## Structure
- downcounter_pkg gains:
  - ctrl_state_t enum {IDLE, COUNT, DONE}
  - constant STEP = 2
  - constant DEFAULT_WIDTH = 8
- Sub-module even_down_core (clk, rst, load, load_val, dec, count) holds the count register.
  - The controller drives load on accept, dec in COUNT when not held and not at zero, and load with 0 on abort.
- The arbiter, FSM and pointer live in even_down_count_ctrl.

## Test plan
- Reset then single job: rst low for 8 ns; req_valid = 01, start0 = 8 → count 8, 6, 4, 2, 0 on successive edges; done = 01 for one cycle after the 5th edge; busy falls one cycle later.
- Odd and zero start: start0 = 7 → loads 6, done after 4 edges. start0 = 1 → loads 0, done after 1 edge.
- Contention/round-robin: both valid from reset with start0 = 4, start1 = 2 → req0 served first (owner 0), then req1 (owner 1); if req0 re-asserts, it is granted only after req1's done.
- Hold: start = 6; hold high for 3 cycles after count = 4 → count stays 4 for 3 cycles; done arrives 3 cycles late; hold asserted during count = 0 does not delay DONE.
- Abort: start = 10; abort at count = 6 → IDLE next edge, count = 0, done stays 00, ptr flips to the other requester.
- Async reset mid-job: rst low while count = 4 → count, busy, done and owner go to 0 immediately, without waiting for a clock edge.
